fp_button_led_ctrl: RTL and testbench

- Parametrised front-panel I/O controller; successor to the plain button-to-WireOut / WireIn-to-LED connection.
- Synchronises and debounces N_BTN active-low buttons and latches sticky press events until the host clears them.
- Drives N_LED LEDs in per-LED modes: off, on, blink, or follow-button.
- Sits between okHost endpoints (WireIn for mode, TriggerIn for clear, WireOut for state/events) and the board pins, all in the ti_clk domain.

---
 rtl/fp_button_led_ctrl.sv | 126 ++++++++++++
 tb/tb_fp_button_led_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_button_led_ctrl.sv
// Front-panel I/O controller: synchronised, debounced active-low buttons with sticky
// press flags, and per-LED off/on/blink/follow drive, all in the ti_clk domain.
module fp_button_led_ctrl #(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned N_LED     = 8,
  parameter int unsigned DB_CYCLES = 48000,
  parameter int unsigned BLINK_DIV = 24000000
) (
  input  logic               ti_clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   button_n,
  output logic [N_BTN-1:0]   btn_state,
  output logic [N_BTN-1:0]   btn_event,
  input  logic [N_BTN-1:0]   event_clear,
  input  logic [2*N_LED-1:0] led_mode,
  output logic [N_LED-1:0]   led_on,
  output logic               blink_phase
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    LED_OFF    = 2'b00,
    LED_ON     = 2'b01,
    LED_BLINK  = 2'b10,
    LED_FOLLOW = 2'b11
  } led_mode_e;

  logic [N_BTN-1:0]   sync1_q, sync1_d;
  logic [N_BTN-1:0]   sync2_q, sync2_d;
  logic [N_BTN-1:0]   sync_c;
  logic [DB_W-1:0]    db_cnt_q [N_BTN];
  logic [DB_W-1:0]    db_cnt_d [N_BTN];
  logic [N_BTN-1:0]   btn_state_q, btn_state_d;
  logic [N_BTN-1:0]   btn_prev_q, btn_prev_d;
  logic [N_BTN-1:0]   btn_event_q, btn_event_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [N_LED-1:0]   led_on_q, led_on_d;

  // Two-flop synchroniser; released level is 1 so reset yields no press edge.
  always_comb begin
    sync1_d = button_n;
    sync2_d = sync1_q;
    sync_c  = ~sync2_q;
  end

  // Per-channel debounce: state follows sync only after DB_CYCLES agreeing samples.
  always_comb begin
    btn_state_d = btn_state_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_c[i] == btn_state_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        btn_state_d[i] = sync_c[i];
        db_cnt_d[i]    = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Sticky press flags; a rising edge beats a simultaneous clear.
  always_comb begin
    btn_prev_d  = btn_state_q;
    btn_event_d = (btn_event_q & ~event_clear) | (btn_state_q & ~btn_prev_q);
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_comb begin
    led_on_d = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      unique case (led_mode_e'(led_mode[2*i +: 2]))
        LED_OFF:    led_on_d[i] = 1'b0;
        LED_ON:     led_on_d[i] = 1'b1;
        LED_BLINK:  led_on_d[i] = blink_phase_q;
        LED_FOLLOW: led_on_d[i] = btn_state_q[i % N_BTN];
        default:    led_on_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      btn_state_q   <= '0;
      btn_prev_q    <= '0;
      btn_event_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_on_q      <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      btn_state_q   <= btn_state_d;
      btn_prev_q    <= btn_prev_d;
      btn_event_q   <= btn_event_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_on_q      <= led_on_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign btn_state   = btn_state_q;
  assign btn_event   = btn_event_q;
  assign led_on      = led_on_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_fp_button_led_ctrl.sv
// Bench for fp_button_led_ctrl: directed scenarios plus random stimulus, every cycle
// checked against a window-based behavioural model of the front panel.
module tb_fp_button_led_ctrl;

  localparam int N_BTN = 4;
  localparam int N_LED = 8;
  localparam int DB    = 4;
  localparam int BD    = 8;

  logic               ti_clk = 1'b0;
  logic               reset;
  logic [N_BTN-1:0]   button_n;
  logic [N_BTN-1:0]   btn_state;
  logic [N_BTN-1:0]   btn_event;
  logic [N_BTN-1:0]   event_clear;
  logic [2*N_LED-1:0] led_mode;
  logic [N_LED-1:0]   led_on;
  logic               blink_phase;

  int tests = 0;
  int fails = 0;

  // Model: raw history, last DB debounce samples per button, cycles since reset.
  bit [N_BTN-1:0] m_raw1, m_raw2, m_state, m_prev, m_event;
  bit [DB-1:0]    m_hist [N_BTN];
  int             m_n;
  bit             m_phase;
  bit [N_LED-1:0] m_led;

  fp_button_led_ctrl #(
    .N_BTN(N_BTN), .N_LED(N_LED), .DB_CYCLES(DB), .BLINK_DIV(BD)
  ) dut (
    .ti_clk(ti_clk), .reset(reset), .button_n(button_n), .btn_state(btn_state),
    .btn_event(btn_event), .event_clear(event_clear), .led_mode(led_mode),
    .led_on(led_on), .blink_phase(blink_phase)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw1 = '1; m_raw2 = '1; m_state = '0; m_prev = '0; m_event = '0;
    for (int i = 0; i < N_BTN; i++) m_hist[i] = '0;
    m_n = 0; m_phase = 1'b0; m_led = '0;
  endtask

  // One clock edge of the panel, computed from the behavioural rules.
  task automatic model_step();
    bit [N_BTN-1:0] old_state;
    old_state = m_state;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode[2*i +: 2])
        2'b00:   m_led[i] = 1'b0;
        2'b01:   m_led[i] = 1'b1;
        2'b10:   m_led[i] = m_phase;
        default: m_led[i] = old_state[i % N_BTN];
      endcase
    end
    m_event = (m_event & ~event_clear) | (old_state & ~m_prev);
    m_prev  = old_state;
    for (int i = 0; i < N_BTN; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], ~m_raw2[i]};
      if (m_hist[i] == {DB{~m_state[i]}}) m_state[i] = ~m_state[i];
    end
    m_raw2  = m_raw1;
    m_raw1  = button_n;
    m_n++;
    m_phase = ((m_n / BD) % 2) == 1;
  endtask

  task automatic compare_model();
    check("btn_state", 16'(btn_state), 16'(m_state));
    check("btn_event", 16'(btn_event), 16'(m_event));
    check("led_on", 16'(led_on), 16'(m_led));
    check("blink_phase", 16'(blink_phase), 16'(m_phase));
  endtask

  // Advance n edges; inputs are changed by the caller just after each negedge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge ti_clk);
      if (!reset) model_step();
      @(negedge ti_clk);
      compare_model();
      #1;
    end
  endtask

  initial begin
    int t2, t6;
    logic l2, l6;

    // Scenario 1: reset with all buttons held low.
    reset = 1'b1; button_n = '0; event_clear = '0; led_mode = '0;
    model_reset();
    step(3);
    check("s1_rst_outputs", 16'({btn_state, btn_event, led_on, blink_phase}), 16'h0);
    reset = 1'b0;
    step(5);
    check("s1_state_pre", 16'(btn_state), 16'h0);
    step(1);
    check("s1_state_6", 16'(btn_state), 16'hF);
    check("s1_event_6", 16'(btn_event), 16'h0);
    step(1);
    check("s1_event_7", 16'(btn_event), 16'hF);

    // Scenario 2: 3-cycle glitch on button 0 is rejected.
    button_n = '1; event_clear = '1;
    step(1);
    event_clear = '0;
    step(8);
    check("s2_idle_state", 16'(btn_state), 16'h0);
    check("s2_idle_event", 16'(btn_event), 16'h0);
    button_n[0] = 1'b0;
    step(3);
    button_n[0] = 1'b1;
    step(10);
    check("s2_glitch_state", 16'(btn_state[0]), 16'h0);
    check("s2_glitch_event", 16'(btn_event[0]), 16'h0);

    // Scenario 3: clean press and release of button 1.
    button_n[1] = 1'b0;
    step(5);
    check("s3_press_pre", 16'(btn_state[1]), 16'h0);
    step(1);
    check("s3_press_6", 16'(btn_state[1]), 16'h1);
    step(1);
    check("s3_event_7", 16'(btn_event[1]), 16'h1);
    button_n[1] = 1'b1;
    step(5);
    check("s3_rel_pre", 16'(btn_state[1]), 16'h1);
    step(1);
    check("s3_rel_6", 16'(btn_state[1]), 16'h0);
    check("s3_event_sticky", 16'(btn_event[1]), 16'h1);

    // Scenario 4: clear collides with the set of button 2's flag.
    button_n[2] = 1'b0;
    step(6);
    event_clear = 4'b0100;
    step(1);
    event_clear = '0;
    check("s4_set_wins", 16'(btn_event[2]), 16'h1);
    step(2);
    event_clear = 4'b0100;
    step(1);
    event_clear = '0;
    check("s4_clear", 16'(btn_event[2]), 16'h0);
    check("s4_other_kept", 16'(btn_event[1]), 16'h1);
    button_n[2] = 1'b1;
    step(8);

    // Scenario 5: LED modes with button 0 pressed.
    button_n = 4'b1110;
    step(8);
    led_mode = 16'b11_10_01_00_11_10_01_00;
    step(2);
    check("s5_static_b3_up", 16'(led_on & 8'b1011_1011), 16'h0022);
    t2 = 0; t6 = 0; l2 = led_on[2]; l6 = led_on[6];
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (led_on[2] !== l2) t2++;
      if (led_on[6] !== l6) t6++;
      l2 = led_on[2]; l6 = led_on[6];
    end
    check("s5_blink2_toggles", 16'(t2), 16'd3);
    check("s5_blink6_toggles", 16'(t6), 16'd3);
    button_n = 4'b0110;
    step(8);
    check("s5_static_b3_dn", 16'(led_on & 8'b1011_1011), 16'h00AA);

    // Scenario 6: reset two cycles into a debounce restarts the count.
    button_n = '1; led_mode = '0;
    step(10);
    button_n = 4'b1110;
    step(4);
    reset = 1'b1;
    model_reset();
    step(1);
    check("s6_in_reset", 16'(btn_state), 16'h0);
    reset = 1'b0;
    step(5);
    check("s6_state_pre", 16'(btn_state[0]), 16'h0);
    step(1);
    check("s6_state_6", 16'(btn_state[0]), 16'h1);

    // Random phase: button flips, clears and mode changes, one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(0, 5) == 0) button_n[b] = ~button_n[b];
      event_clear = ($urandom_range(0, 3) == 0) ? N_BTN'($urandom) : '0;
      if (c % 64 == 0) led_mode = (2*N_LED)'($urandom);
      if (c == 700) begin
        reset = 1'b1;
        model_reset();
      end
      if (c == 702) reset = 1'b0;
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
